// File: rtl/tone_pkg.sv
// Shared definitions for the FFT peak detector: frame geometry, datapath
// widths, the controller state type and the magnitude summing helper.
package tone_pkg;

    localparam int FFT_N       = 256;
    localparam int SEARCH_BINS = 128;
    localparam int SAMPLE_W    = 16;
    localparam int MAG_W       = 33;
    localparam int PROD_W      = 2 * SAMPLE_W;
    localparam int IDX_W       = 8;

    // Index of the final beat of a full frame.
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FFT_N - 1);
    // Highest bin that may become the peak.
    localparam logic [IDX_W-1:0] SEARCH_LAST = IDX_W'(SEARCH_BINS - 1);
    // First bin past the search range; it may still supply right_mag.
    localparam logic [IDX_W-1:0] RIGHT_EDGE  = IDX_W'(SEARCH_BINS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    // Squares of signed 16-bit values are never negative and stay below 2^31,
    // so zero-extending both before the add gives the exact 33-bit sum.
    function automatic logic [MAG_W-1:0] mag_add(input logic signed [PROD_W-1:0] a,
                                                 input logic signed [PROD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// Two-stage pipelined |X|^2 = re^2 + im^2 unit. A tag (the bin index) and a
// valid flag travel alongside the data so the consumer knows which bin each
// magnitude belongs to, regardless of input stalls.
module mag_sq
    import tone_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_re,
    input  logic signed [SAMPLE_W-1:0] in_im,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [MAG_W-1:0]           out_mag,
    output logic [TAG_W-1:0]           out_tag
);

    logic signed [PROD_W-1:0] re_sq;
    logic signed [PROD_W-1:0] im_sq;
    logic                     s1_valid;
    logic [TAG_W-1:0]         s1_tag;

    // Stage 1: full-width signed squares of both components.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_sq    <= '0;
            im_sq    <= '0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else begin
            re_sq    <= PROD_W'(in_re) * PROD_W'(in_re);
            im_sq    <= PROD_W'(in_im) * PROD_W'(in_im);
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2: exact 33-bit sum of the two squares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_mag   <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
        end else begin
            out_mag   <= mag_add(re_sq, im_sq);
            out_valid <= s1_valid;
            out_tag   <= s1_tag;
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// FFT peak detector: consumes one 256-beat FFT frame, finds the bin with the
// largest |X|^2 in the lower half of the spectrum, and reports it together
// with its two neighbours' magnitudes and a framing-error flag.
// Build option: define PEAK_SKIP_DC_EN to exclude bins 0 and 1 from the search.
module fft_peak_detect
    import tone_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          fft_m_data_tdata,
    input  logic                 fft_m_data_tvalid,
    input  logic                 fft_m_data_tlast,
    output logic                 fft_m_data_tready,
    output logic [IDX_W-1:0]     peak_bin,
    output logic [MAG_W-1:0]     peak_mag,
    output logic [MAG_W-1:0]     left_mag,
    output logic [MAG_W-1:0]     right_mag,
    output logic                 peak_valid,
    output logic                 frame_err
);

`ifdef PEAK_SKIP_DC_EN
    localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(2);
`else
    localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(0);
`endif

    state_t             state;
    logic [IDX_W-1:0]   beat_idx;
    logic               drain_cnt;
    logic               err_pend;

    logic               accept;
    logic               frame_end;
    logic               frame_bad;

    logic               m_valid;
    logic [MAG_W-1:0]   m_mag;
    logic [IDX_W-1:0]   m_bin;
    logic               in_search;

    logic [MAG_W-1:0]   run_max;
    logic [IDX_W-1:0]   run_bin;
    logic [MAG_W-1:0]   run_left;
    logic [MAG_W-1:0]   run_right;
    logic               right_pend;
    logic [MAG_W-1:0]   prev_mag;

    assign accept    = fft_m_data_tvalid && fft_m_data_tready;
    assign frame_end = fft_m_data_tlast || (beat_idx == LAST_IDX);
    assign frame_bad = !(fft_m_data_tlast && (beat_idx == LAST_IDX));

`ifdef PEAK_SKIP_DC_EN
    assign in_search = (m_bin <= SEARCH_LAST) && (m_bin >= FIRST_BIN);
`else
    assign in_search = (m_bin <= SEARCH_LAST);
`endif

    mag_sq #(
        .TAG_W (IDX_W)
    ) u_mag_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_re     (fft_m_data_tdata[15:0]),
        .in_im     (fft_m_data_tdata[31:16]),
        .in_tag    (beat_idx),
        .out_valid (m_valid),
        .out_mag   (m_mag),
        .out_tag   (m_bin)
    );

    // Frame controller: counts beats, waits for the magnitude pipeline to
    // empty, then publishes the running result with a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            fft_m_data_tready <= 1'b0;
            beat_idx          <= '0;
            drain_cnt         <= 1'b0;
            err_pend          <= 1'b0;
            peak_valid        <= 1'b0;
            frame_err         <= 1'b0;
            peak_bin          <= '0;
            peak_mag          <= '0;
            left_mag          <= '0;
            right_mag         <= '0;
        end else begin
            peak_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    fft_m_data_tready <= 1'b1;
                    if (accept) begin
                        beat_idx <= beat_idx + IDX_W'(1);
                        if (frame_end) begin
                            state             <= ST_DRAIN;
                            fft_m_data_tready <= 1'b0;
                            drain_cnt         <= 1'b0;
                            err_pend          <= frame_bad;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DRAIN: begin
                    fft_m_data_tready <= 1'b0;
                    if (drain_cnt) begin
                        state <= ST_REPORT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    state             <= ST_IDLE;
                    fft_m_data_tready <= 1'b1;
                    beat_idx          <= '0;
                    peak_valid        <= 1'b1;
                    frame_err         <= err_pend;
                    peak_bin          <= run_bin;
                    peak_mag          <= run_max;
                    left_mag          <= run_left;
                    right_mag         <= run_right;
                end
                default: begin
                    state             <= ST_IDLE;
                    fft_m_data_tready <= 1'b0;
                end
            endcase
        end
    end

    // Running peak search over magnitudes as they leave the pipeline; the
    // state is cleared as the result is published so the next frame starts
    // from a zero maximum.
    always_ff @(posedge clk) begin
        if (!rst_n || (state == ST_REPORT)) begin
            run_max    <= '0;
            run_bin    <= FIRST_BIN;
            run_left   <= '0;
            run_right  <= '0;
            right_pend <= 1'b0;
            prev_mag   <= '0;
        end else if (m_valid) begin
            prev_mag <= m_mag;
            if (in_search && (m_mag > run_max)) begin
                run_max    <= m_mag;
                run_bin    <= m_bin;
                run_left   <= (m_bin == '0) ? '0 : prev_mag;
                run_right  <= '0;
                right_pend <= 1'b1;
            end else if (right_pend) begin
                if (m_bin <= RIGHT_EDGE) begin
                    run_right <= m_mag;
                end
                right_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect. Frames are described as
// sparse tables of (re, im) per bin; expected results are hand-computed.
// Honours PEAK_SKIP_DC_EN when choosing expected values for DC-sensitive frames.
module tb_fft_peak_detect;

    logic        clk;
    logic        rst_n;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [7:0]  peak_bin;
    logic [32:0] peak_mag;
    logic [32:0] left_mag;
    logic [32:0] right_mag;
    logic        peak_valid;
    logic        frame_err;

    logic signed [15:0] re_tab [256];
    logic signed [15:0] im_tab [256];

    int checks;
    int errors;
    int lat;
    int tready_low;
    int tready_c4;
    int pv_after;
    int pv_count;

    fft_peak_detect dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fft_m_data_tdata  (tdata),
        .fft_m_data_tvalid (tvalid),
        .fft_m_data_tlast  (tlast),
        .fft_m_data_tready (tready),
        .peak_bin          (peak_bin),
        .peak_mag          (peak_mag),
        .left_mag          (left_mag),
        .right_mag         (right_mag),
        .peak_valid        (peak_valid),
        .frame_err         (frame_err)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 256; i++) begin
            re_tab[i] = '0;
            im_tab[i] = '0;
        end
    endtask

    // Sends beats 0..nbeats-1 from the tables, optionally with tlast on the
    // final beat and short tvalid gaps, then watches for the result pulse.
    task automatic applyStimulus(input int nbeats, input bit with_last, input int stall_every);
        int guard;
        for (int b = 0; b < nbeats; b++) begin
            if (stall_every != 0 && (b % stall_every) == 3) begin
                tvalid = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
            tdata  = {im_tab[b], re_tab[b]};
            tvalid = 1'b1;
            tlast  = with_last && (b == nbeats - 1);
            guard  = 0;
            while (!tready && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            @(posedge clk);
            #1;
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
        lat        = 0;
        tready_low = 0;
        tready_c4  = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 3 && !tready) tready_low++;
            if (c == 4) tready_c4 = int'(tready);
            if (peak_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        pv_after = int'(peak_valid);
    endtask

    task automatic check_frame(input string name, input int exp_bin, input longint exp_mag,
                               input longint exp_left, input longint exp_right, input int exp_err);
        checkOutput({name, "_latency"},   64'(lat),        64'd4);
        checkOutput({name, "_tready_lo"}, 64'(tready_low), 64'd3);
        checkOutput({name, "_tready_c4"}, 64'(tready_c4),  64'd1);
        checkOutput({name, "_pulse"},     64'(pv_after),   64'd0);
        checkOutput({name, "_bin"},       64'(peak_bin),   64'(exp_bin));
        checkOutput({name, "_mag"},       64'(peak_mag),   64'(exp_mag));
        checkOutput({name, "_left"},      64'(left_mag),   64'(exp_left));
        checkOutput({name, "_right"},     64'(right_mag),  64'(exp_right));
        checkOutput({name, "_err"},       64'(frame_err),  64'(exp_err));
    endtask

    // Directed sequence of frames.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        tdata  = '0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tready",     64'(tready),     64'd0);
        checkOutput("rst_peak_valid", 64'(peak_valid), 64'd0);
        checkOutput("rst_frame_err",  64'(frame_err),  64'd0);
        checkOutput("rst_peak_bin",   64'(peak_bin),   64'd0);
        checkOutput("rst_peak_mag",   64'(peak_mag),   64'd0);
        checkOutput("rst_left_mag",   64'(left_mag),   64'd0);
        checkOutput("rst_right_mag",  64'(right_mag),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_tready", 64'(tready), 64'd1);

        // Single tone at bin 10.
        clear_tab();
        re_tab[10] = 16'sd1000;
        applyStimulus(256, 1'b1, 0);
        check_frame("tone10", 10, 1000000, 0, 0, 0);

        // Three neighbouring bins, with tvalid stalls.
        clear_tab();
        re_tab[20] = 16'sd300;   im_tab[20] = 16'sd400;
        re_tab[21] = -16'sd2000;
        im_tab[22] = 16'sd1500;
        applyStimulus(256, 1'b1, 7);
        check_frame("tri21", 21, 4000000, 250000, 2250000, 0);

        // Full-scale tie: lowest bin wins; upper-half bin ignored.
        clear_tab();
        re_tab[5] = -16'sd32768;  im_tab[5] = -16'sd32768;
        re_tab[9] = -16'sd32768;  im_tab[9] = -16'sd32768;
        re_tab[200] = 16'sd32767;
        applyStimulus(256, 1'b1, 0);
        check_frame("tie5", 5, 64'd2147483648, 0, 0, 0);

        // Peak at the top of the search range; bin 128 supplies right_mag only.
        clear_tab();
        re_tab[127] = 16'sd10;
        re_tab[128] = 16'sd20;
        re_tab[129] = 16'sd30000;
        applyStimulus(256, 1'b1, 0);
        check_frame("edge127", 127, 100, 0, 400, 0);

        // Early tlast on beat 99.
        clear_tab();
        re_tab[50] = 16'sd123;
        applyStimulus(100, 1'b1, 0);
        check_frame("early", 50, 15129, 0, 0, 1);

        // Normal frame afterwards clears the error.
        clear_tab();
        re_tab[60] = -16'sd5;  im_tab[60] = 16'sd7;
        applyStimulus(256, 1'b1, 0);
        check_frame("recover", 60, 74, 0, 0, 0);

        // Beat 255 without tlast.
        clear_tab();
        re_tab[3] = 16'sd2;
        applyStimulus(256, 1'b0, 0);
        check_frame("nolast", 3, 4, 0, 0, 1);

        // Reset in the middle of a frame: no result for the partial frame.
        clear_tab();
        re_tab[30] = 16'sd500;
        for (int b = 0; b < 60; b++) begin
            tdata  = {im_tab[b], re_tab[b]};
            tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_tready", 64'(tready), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        pv_count = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (peak_valid) pv_count++;
        end
        checkOutput("midrst_no_pulse", 64'(pv_count), 64'd0);
        checkOutput("midrst_peak_bin", 64'(peak_bin), 64'd0);
        checkOutput("midrst_tready1",  64'(tready),   64'd1);

        clear_tab();
        re_tab[7] = 16'sd900;
        applyStimulus(256, 1'b1, 0);
        check_frame("after_rst", 7, 810000, 0, 0, 0);

        // Strong DC bin versus a small tone at bin 40.
        clear_tab();
        re_tab[0]  = 16'sd30000;
        re_tab[40] = 16'sd100;
        applyStimulus(256, 1'b1, 0);
`ifdef PEAK_SKIP_DC_EN
        check_frame("dc", 40, 10000, 0, 0, 0);
`else
        check_frame("dc", 0, 900000000, 0, 0, 0);
`endif

        // All-zero frame reports the lowest reportable bin with zero magnitude.
        clear_tab();
        applyStimulus(256, 1'b1, 0);
`ifdef PEAK_SKIP_DC_EN
        check_frame("zero", 2, 0, 0, 0, 0);
`else
        check_frame("zero", 0, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameters: none; frame length and widths come from the shared package.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all logic on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 fft_m_data_tdata  in  32  FFT output beat: real = [15:0], imag = [31:16], both signed.
REQ-006 fft_m_data_tvalid  in  1  FFT output beat valid.
REQ-007 fft_m_data_tlast  in  1  last beat of an FFT frame.
REQ-008 fft_m_data_tready  out  1  block accepts a beat.
REQ-009 peak_bin  out  8  bin index of the maximum |X|^2 within the search range.
REQ-010 peak_mag  out  33  |X|^2 of peak_bin.
REQ-011 left_mag / right_mag  out  33 each  |X|^2 of bin peak_bin-1 and bin peak_bin+1.
REQ-012 peak_valid  out  1  one-cycle pulse; result outputs are updated on this cycle.
REQ-013 frame_err  out  1  set with peak_valid when tlast and beat 255 do not coincide.

Function
REQ-014 A beat is accepted on any cycle where tvalid=1 and tready=1.
REQ-015 FSM states: IDLE, ACCUM, DRAIN, REPORT.
REQ-016 IDLE -> ACCUM on the first accepted beat.
REQ-017 ACCUM -> DRAIN when the accepted beat has tlast=1 or beat index=255, whichever comes first.
REQ-018 DRAIN -> REPORT after the magnitude pipeline is empty (2 cycles).
REQ-019 REPORT -> IDLE after 1 cycle.
REQ-020 tready=1 in IDLE and ACCUM; tready=0 in DRAIN and REPORT.
REQ-021 Beat index counter: 8 bits; cleared on entering IDLE; increments per accepted beat.
REQ-022 Magnitude: re^2 + im^2 computed from 16x16 signed products (32 bits each), summed to 33 bits unsigned; 2-stage pipeline with no truncation.
REQ-023 Search range is bins 0..127. Magnitudes of bins 128..255 are discarded, except bin 128, which is used only as a candidate right_mag.
REQ-024 Peak update: strictly greater than the current max; on a tie, the lowest bin wins. The running max is 0 at frame start, so an all-zero frame reports bin 0, magnitude 0.
REQ-025 left_mag takes the previous bin's magnitude when the peak updates, or 0 if the peak is bin 0.
REQ-026 right_mag takes the magnitude of the next bin following the latest peak update.
REQ-027 peak_valid pulses in REPORT, exactly 4 cycles after the terminating beat is accepted.
REQ-028 peak_bin, peak_mag, left_mag, right_mag and frame_err hold their values until the next peak_valid.
REQ-029 Early tlast (index < 255): frame ends; frame_err=1; the result covers the beats received.
REQ-030 Beat 255 without tlast: frame ends; frame_err=1.
REQ-031 tvalid stalls mid-frame do not affect the result.

Reset
REQ-032 rst_n=0 sampled at a clock edge: FSM to IDLE; counter, running max and pipeline cleared.
REQ-033 Reset values: tready=0 during reset and 1 the cycle after; peak_valid=0; frame_err=0; peak_bin=0; all magnitude outputs 0.
REQ-034 Reset mid-frame discards the partial frame; no peak_valid is produced for it.

Configuration
REQ-035 Macro PEAK_SKIP_DC_EN defined: bins 0 and 1 are excluded from the peak search. The lowest reportable bin is 2, and left_mag then takes bin 1's magnitude.
REQ-036 Macro PEAK_SKIP_DC_EN undefined: the search covers bins 0..127 as in REQ-023.

Structure
REQ-037 Shared package tone_pkg holds: FFT_N=256, SEARCH_BINS=128, SAMPLE_W=16, MAG_W=33, and the FSM state typedef.
REQ-038 One sub-module, mag_sq: the 2-stage pipelined re^2+im^2 unit, instantiated once.

Verification
REQ-039 256-beat frame, bin 10 = (1000,0), all other beats 0, tlast on beat 255 -> peak_bin=10, peak_mag=1000000, left_mag=0, right_mag=0, frame_err=0, peak_valid 4 cycles after the last beat.
REQ-040 Bins 20, 21, 22 = (300,400), (-2000,0), (0,1500) -> peak_bin=21, peak_mag=4000000, left_mag=250000, right_mag=2250000.
REQ-041 Bins 5 and 9 both = (-32768,-32768) -> peak_bin=5, peak_mag=2147483648 (33-bit exact); bin 200 = (32767,0) is ignored.
REQ-042 tlast on beat 99 -> frame_err=1, result valid, tready=0 for the 3 cycles after the tlast beat; then a normal frame -> frame_err=0.
REQ-043 rst_n low at beat 60 of a frame containing a peak at bin 30 -> no peak_valid; the next clean frame with a peak at bin 7 reports bin 7.
REQ-044 With PEAK_SKIP_DC_EN: bin 0 = (30000,0), bin 40 = (100,0) -> peak_bin=40; without the macro, the same frame gives peak_bin=0.
